mc_core: RTL

Parametrised multi-cycle processor core: the second-generation instruction-execution block of the compute design. It fetches 32-bit instructions over a single request/acknowledge memory port, executes them against a register file whose size and data width are parameters, and keeps global zero/carry flags. It adds load/store, conditional branches and a halt state, and it tolerates memory wait states of any length.

---
 rtl/mc_core.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mc_core.sv
// mc_core: multi-cycle core; fetch, execute and optional memory phase per instruction
// over one request/acknowledge port that tolerates any number of wait states.
module mc_core #(
  parameter int                DATA_W   = 32,
  parameter int                NREGS    = 8,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                                   clock,
  input  logic                                   reset,
  output logic                                   mem_req,
  output logic                                   mem_we,
  output logic [ADDR_W-1:0]                      mem_addr,
  output logic [DATA_W-1:0]                      mem_wdata,
  input  logic [((DATA_W > 32) ? DATA_W : 32)-1:0] mem_rdata,
  input  logic                                   mem_ack,
  output logic [ADDR_W-1:0]                      pc,
  output logic                                   halted,
  output logic                                   illegal
);

  localparam int RI_W = $clog2(NREGS);

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_LDI  = 4'd6;
  localparam logic [3:0] OP_LD   = 4'd7;
  localparam logic [3:0] OP_ST   = 4'd8;
  localparam logic [3:0] OP_BZ   = 4'd9;
  localparam logic [3:0] OP_BC   = 4'd10;
  localparam logic [3:0] OP_JR   = 4'd11;
  localparam logic [3:0] OP_CMP  = 4'd12;
  localparam logic [3:0] OP_U13  = 4'd13;
  localparam logic [3:0] OP_U14  = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  state_t            state, state_nxt;
  logic [31:0]       instr;
  logic [DATA_W-1:0] regs [NREGS];
  logic              flag_z, flag_c;

  logic [3:0]        op;
  logic [RI_W-1:0]   rd, ra, rb;
  logic [DATA_W-1:0] ra_val, rb_val, imm_d;
  logic [ADDR_W-1:0] imm_a, pc_inc, ea, pc_exec;
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, rd_wr, flags_wr, is_mem_op;

  // Field bits above RI_W and read-data bits beyond the used width are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{mem_rdata, instr};

  assign op        = instr[3:0];
  assign rd        = instr[4 +: RI_W];
  assign ra        = instr[8 +: RI_W];
  assign rb        = instr[12 +: RI_W];
  assign ra_val    = regs[ra];
  assign rb_val    = regs[rb];
  assign imm_d     = DATA_W'($signed(instr[31:16]));
  assign imm_a     = ADDR_W'($signed(instr[31:16]));
  assign pc_inc    = pc + ADDR_W'(1);
  assign ea        = ADDR_W'(ra_val) + imm_a;
  assign sum_ext   = {1'b0, ra_val} + {1'b0, rb_val};
  assign is_mem_op = (op == OP_LD) || (op == OP_ST);

  always_comb begin
    alu_res  = '0;
    alu_c    = 1'b0;
    rd_wr    = 1'b0;
    flags_wr = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res  = sum_ext[DATA_W-1:0];
        alu_c    = sum_ext[DATA_W];
        rd_wr    = 1'b1;
        flags_wr = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        alu_res  = ra_val - rb_val;
        alu_c    = (ra_val < rb_val);
        rd_wr    = (op == OP_SUB);
        flags_wr = 1'b1;
      end
      OP_AND: begin
        alu_res  = ra_val & rb_val;
        rd_wr    = 1'b1;
        flags_wr = 1'b1;
      end
      OP_OR: begin
        alu_res  = ra_val | rb_val;
        rd_wr    = 1'b1;
        flags_wr = 1'b1;
      end
      OP_XOR: begin
        alu_res  = ra_val ^ rb_val;
        rd_wr    = 1'b1;
        flags_wr = 1'b1;
      end
      OP_LDI: begin
        alu_res = imm_d;
        rd_wr   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_exec = pc_inc;
    case (op)
      OP_BZ: if (flag_z) pc_exec = pc_inc + imm_a;
      OP_BC: if (flag_c) pc_exec = pc_inc + imm_a;
      OP_JR: pc_exec = ADDR_W'(ra_val);
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Bus strobes come straight from state so a reset drops mem_req without waiting for an edge.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        illegal = (op == OP_U13) || (op == OP_U14);
        if (is_mem_op)          state_nxt = S_MEM;
        else if (op == OP_HALT) state_nxt = S_HALT;
        else                    state_nxt = S_FETCH;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op == OP_ST);
        if (mem_ack) state_nxt = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
  end

  // mem_addr/mem_wdata are loaded on the edge that enters a request state and held through it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      mem_addr  <= '0;
      mem_wdata <= '0;
      instr     <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE:  mem_addr <= pc;
        S_FETCH: if (mem_ack) instr <= mem_rdata[31:0];
        S_EXEC: begin
          if (rd_wr) regs[rd] <= alu_res;
          if (flags_wr) begin
            flag_z <= (alu_res == '0);
            flag_c <= alu_c;
          end
          if (is_mem_op) begin
            mem_addr  <= ea;
            mem_wdata <= rb_val;
          end else if (op != OP_HALT) begin
            pc       <= pc_exec;
            mem_addr <= pc_exec;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            if (op == OP_LD) regs[rd] <= mem_rdata[DATA_W-1:0];
            pc       <= pc_inc;
            mem_addr <= pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
